// File: rtl/bpu_assoc.sv
// Set-associative front-end branch predictor: NUM_WAYS-way BTB with per-entry
// saturating direction counters, per-set round-robin victims and a circular RAS.
module bpu_assoc #(
    parameter int NUM_SETS   = 128,
    parameter int NUM_WAYS   = 4,
    parameter int CTR_WIDTH  = 2,
    parameter int NUM_RAS    = 16,
    parameter int ADDR_WIDTH = 32,
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  query_valid,
    input  logic [ADDR_WIDTH-1:0] query_pc,
    input  logic                  flush,
    output logic                  predict_valid,
    output logic [ADDR_WIDTH-1:0] predict_target,
    output logic                  predict_hit,
    output logic [WW-1:0]         predict_way,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic [1:0]            upd_type,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    input  logic                  upd_call,
    input  logic                  upd_ret,
    input  logic                  upd_same_link,
    input  logic [ADDR_WIDTH-1:0] upd_link_pc
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = ADDR_WIDTH - IW - 2;
    localparam int RW = $clog2(NUM_RAS);

    localparam logic [1:0] T_BR  = 2'b00;
    localparam logic [1:0] T_RET = 2'b11;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_T   = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    localparam logic [CTR_WIDTH-1:0] CTR_NT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    logic [NUM_WAYS-1:0]   ent_valid  [NUM_SETS];
    logic [TW-1:0]         ent_tag    [NUM_SETS][NUM_WAYS];
    logic [ADDR_WIDTH-1:0] ent_target [NUM_SETS][NUM_WAYS];
    logic [1:0]            ent_type   [NUM_SETS][NUM_WAYS];
    logic [CTR_WIDTH-1:0]  ent_ctr    [NUM_SETS][NUM_WAYS];
    logic [WW-1:0]         victim     [NUM_SETS];

    logic [ADDR_WIDTH-1:0] ras [NUM_RAS];
    logic [RW-1:0]         ras_top;
    logic [RW:0]           ras_count;

    logic                  pending;
    logic [TW-1:0]         cap_tag_q;
    logic [NUM_WAYS-1:0]   cap_valid;
    logic [TW-1:0]         cap_tag    [NUM_WAYS];
    logic [ADDR_WIDTH-1:0] cap_target [NUM_WAYS];
    logic [1:0]            cap_type   [NUM_WAYS];
    logic [NUM_WAYS-1:0]   cap_dir;

    logic [IW-1:0] q_index, u_index;
    logic [TW-1:0] q_tag, u_tag;
    logic          unused_pc_bits;

    assign q_index        = query_pc[IW+1:2];
    assign q_tag          = query_pc[ADDR_WIDTH-1:IW+2];
    assign u_index        = upd_pc[IW+1:2];
    assign u_tag          = upd_pc[ADDR_WIDTH-1:IW+2];
    assign unused_pc_bits = ^{query_pc[1:0], upd_pc[1:0]};

    // Snapshot of the whole set; the response is built from it next cycle, so
    // a same-cycle update to this set is never visible to this query.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending   <= 1'b0;
            cap_valid <= '0;
        end else begin
            pending <= query_valid & ~flush;
            if (query_valid) begin
                cap_tag_q <= q_tag;
                cap_valid <= ent_valid[q_index];
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cap_tag[w]    <= ent_tag[q_index][w];
                    cap_target[w] <= ent_target[q_index][w];
                    cap_type[w]   <= ent_type[q_index][w];
                    cap_dir[w]    <= ent_ctr[q_index][w][CTR_WIDTH-1];
                end
            end
        end
    end

    logic          any_match, hit, dir;
    logic [WW-1:0] hit_way;
    logic [1:0]    sel_type;

    always_comb begin
        any_match = 1'b0;
        hit_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (cap_valid[w] && cap_tag[w] == cap_tag_q) begin
                any_match = 1'b1;
                hit_way   = WW'(w);
            end
        end
        hit      = pending & any_match;
        sel_type = cap_type[hit_way];
        case (sel_type)
            T_BR:    dir = cap_dir[hit_way];
            T_RET:   dir = (ras_count != '0);
            default: dir = 1'b1;
        endcase
        predict_hit    = hit;
        predict_way    = hit ? hit_way : '0;
        predict_valid  = hit & ~flush & dir;
        predict_target = '0;
        if (hit) predict_target = (sel_type == T_RET) ? ras[ras_top] : cap_target[hit_way];
    end

    logic                 u_hit, u_free;
    logic [WW-1:0]        u_way, u_free_way, alloc_way, victim_next;
    logic [CTR_WIDTH-1:0] u_ctr, ctr_next, ctr_new;

    always_comb begin
        u_hit      = 1'b0;
        u_way      = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (ent_valid[u_index][w] && ent_tag[u_index][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WW'(w);
            end
            if (!ent_valid[u_index][w]) begin
                u_free     = 1'b1;
                u_free_way = WW'(w);
            end
        end
        alloc_way   = u_free ? u_free_way : victim[u_index];
        victim_next = (victim[u_index] == WW'(NUM_WAYS - 1)) ? '0 : victim[u_index] + 1'b1;
        u_ctr       = ent_ctr[u_index][u_way];
        if (upd_taken) ctr_next = (u_ctr == CTR_MAX) ? u_ctr : u_ctr + 1'b1;
        else           ctr_next = (u_ctr == '0)      ? u_ctr : u_ctr - 1'b1;
        if (upd_type == T_BR) ctr_new = upd_taken ? CTR_T : CTR_NT;
        else                  ctr_new = CTR_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                ent_valid[s] <= '0;
                victim[s]    <= '0;
                for (int w = 0; w < NUM_WAYS; w++) ent_ctr[s][w] <= '0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_type == T_BR) ent_ctr[u_index][u_way] <= ctr_next;
                if (upd_mispredict) begin
                    ent_target[u_index][u_way] <= upd_target;
                    ent_type[u_index][u_way]   <= upd_type;
                end
            end else if (upd_mispredict) begin
                ent_valid[u_index][alloc_way]  <= 1'b1;
                ent_tag[u_index][alloc_way]    <= u_tag;
                ent_target[u_index][alloc_way] <= upd_target;
                ent_type[u_index][alloc_way]   <= upd_type;
                ent_ctr[u_index][alloc_way]    <= ctr_new;
                if (!u_free) victim[u_index] <= victim_next;
            end
        end
    end

    logic do_push, do_pop, do_swap;
    assign do_push = upd_call & (~upd_ret | upd_same_link);
    assign do_pop  = upd_ret & ~upd_call;
    assign do_swap = upd_call & upd_ret & ~upd_same_link;

    // Full pushes wrap onto the oldest slot; count saturates at NUM_RAS.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_top   <= '0;
            ras_count <= '0;
        end else if (upd_valid) begin
            if (do_push) begin
                ras_top                   <= ras_top + 1'b1;
                ras[ras_top + RW'(1)]     <= upd_link_pc;
                if (ras_count != (RW+1)'(NUM_RAS)) ras_count <= ras_count + 1'b1;
            end else if (do_pop) begin
                if (ras_count != '0) begin
                    ras_top   <= ras_top - 1'b1;
                    ras_count <= ras_count - 1'b1;
                end
            end else if (do_swap) begin
                ras[ras_top] <= upd_link_pc;
                if (ras_count == '0) ras_count <= (RW+1)'(1);
            end
        end
    end
endmodule
